pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised next-PC register and status sequencer for the Y86-64 core. Each enabled cycle it commits one instruction's control flow: it selects the next PC from valP, valC or valM, tracks processor status (AOK/HLT/ADR/INS) and keeps a return-address stack (RAS) for ret prediction checking. It also maintains a retired-instruction counter. It sits after the memory stage and feeds fetch.

Parameters:
ADDR_W, 64, width of PC and address inputs
RESET_PC, 0, PC value loaded on reset
RAS_DEPTH, 8, return-address stack entries (power of two, >= 2)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  commit strobe; 0 = hold all state
instr_valid  input  1  current icode/operands valid
icode  input  4  instruction code of committing instruction
cnd  input  1  jXX condition result
imem_error  input  1  fetch address error for this instruction
valC  input  ADDR_W  constant/destination word
valM  input  ADDR_W  value read from memory (ret target)
valP  input  ADDR_W  fall-through PC
pc  output  ADDR_W  current PC (registered)
stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS (registered)
ras_top  output  ADDR_W  top RAS entry; 0 when empty
ras_empty  output  1  RAS holds no entries
ras_overflow  output  1  sticky: a push occurred while full
ras_mispredict  output  1  one-cycle pulse: ret target != predicted
retired  output  CNT_W  committed instruction count

Behaviour:
- Reset (rst_n=0 at clk edge): pc=RESET_PC, stat=1, RAS cleared (count 0), ras_empty=1, ras_top=0, ras_overflow=0, ras_mispredict=0, retired=0. Reset overrides en; mid-operation reset discards all RAS contents.
- Commit occurs when en=1, instr_valid=1 and stat=1 (AOK). Otherwise pc, stat, RAS, retired hold; ras_mispredict=0.
- Commit priority: imem_error=1 -> stat=3, pc holds, no RAS op, retired unchanged. Else icode > 4'hB -> stat=4, pc holds. Else by icode:
  - 0 halt: stat=2, pc holds, retired+1.
  - 1,2,3,4,5,6,A,B: pc=valP.
  - 7 jXX: pc = cnd ? valC : valP.
  - 8 call: pc=valC; push valP onto RAS.
  - 9 ret: pc=valM; pop RAS.
  - retired increments by 1 for every non-error commit; wraps modulo 2^CNT_W.
- Once stat != 1, the block is frozen until reset (sticky terminal state).
- Latency: all outputs registered, visible the cycle after the committing edge.
- RAS: circular buffer with pointer and saturating count (0..RAS_DEPTH).
  - Push while full: overwrites oldest entry, count stays RAS_DEPTH, ras_overflow set (sticky until reset).
  - Pop while empty: no state change, ras_mispredict stays 0.
  - Pop while non-empty: compare top to valM; mismatch -> ras_mispredict=1 for exactly one cycle; entry removed regardless.
  - ras_top/ras_empty reflect post-update state.
- All address arithmetic is ADDR_W wide; no sign extension or truncation inside the block.
- ras_mispredict is informational; it never alters pc.

Test Plan:
- Reset with RESET_PC=64'h100, then 3 commits icode=1, valP=102,104,106 -> pc=0x106, retired=3, stat=1.
- jXX: icode=7, valC=0x400, valP=0x20A, cnd=1 -> pc=0x400; repeat cnd=0 -> pc=0x20A.
- call valC=0x500 valP=0x109 then ret valM=0x109 -> pc=0x500 then 0x109, ras_empty returns to 1, no mispredict; ret with valM=0x999 after call(valP=0x109) -> ras_mispredict pulses one cycle, pc=0x999.
- 9 consecutive calls (RAS_DEPTH=8) -> ras_overflow=1, 8 rets pop newest 8 valP values in LIFO order, 9th ret with empty RAS -> pc=valM, no mispredict.
- halt, then icode=1 commits with en=1 -> stat=2, pc and retired frozen; imem_error=1 on fresh run -> stat=3; icode=4'hC -> stat=4.
- en=0 for 5 cycles mid-program -> no output changes; rst_n=0 after 4 pushes -> RAS empty, pc=RESET_PC, stat=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC register, status FSM, return-address stack and retired counter
//   clk, rst_n (sync, active low), en (commit strobe)
//   instr_valid, icode, cnd, imem_error, valC, valM, valP : committing instruction
//   pc, stat (1 AOK, 2 HLT, 3 ADR, 4 INS)                  : registered control flow
//   ras_top, ras_empty, ras_overflow, ras_mispredict      : return-address stack status
//   retired                                               : committed instruction count
module pc_sequencer #(
    parameter int ADDR_W = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int RAS_DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              instr_valid,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic              imem_error,
    input  logic [ADDR_W-1:0] valC,
    input  logic [ADDR_W-1:0] valM,
    input  logic [ADDR_W-1:0] valP,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        stat,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_overflow,
    output logic              ras_mispredict,
    output logic [CNT_W-1:0]  retired
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    typedef enum logic [2:0] {AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4} stat_t;

    stat_t             state, state_nx;
    logic [ADDR_W-1:0] pc_q, pc_nx;
    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     top_idx;
    logic [CW-1:0]     cnt;
    logic              full, push, pop, inc;

    // ptr is the next write slot; when full it also points at the oldest entry,
    // so a push while full overwrites the oldest without extra logic.
    assign top_idx        = ptr - PW'(1);
    assign full           = cnt == CW'(RAS_DEPTH);
    assign ras_empty      = cnt == '0;
    assign ras_top        = ras_empty ? '0 : mem[top_idx];
    assign pc             = pc_q;
    assign stat           = state;

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        push     = 1'b0;
        pop      = 1'b0;
        inc      = 1'b0;
        if (en && instr_valid && state == AOK) begin
            if (imem_error)
                state_nx = ADR;
            else if (icode > 4'hB)
                state_nx = INS;
            else begin
                inc = 1'b1;
                case (icode)
                    4'h0: state_nx = HLT;
                    4'h7: pc_nx = cnd ? valC : valP;
                    4'h8: begin pc_nx = valC; push = 1'b1; end
                    4'h9: begin pc_nx = valM; pop = 1'b1; end
                    default: pc_nx = valP;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= AOK;
            pc_q           <= RESET_PC;
            ptr            <= '0;
            cnt            <= '0;
            ras_overflow   <= 1'b0;
            ras_mispredict <= 1'b0;
            retired        <= '0;
        end else begin
            state          <= state_nx;
            pc_q           <= pc_nx;
            ras_mispredict <= pop && !ras_empty && mem[top_idx] != valM;
            if (inc)
                retired <= retired + CNT_W'(1);
            if (push) begin
                mem[ptr] <= valP;
                ptr      <= ptr + PW'(1);
                if (full)
                    ras_overflow <= 1'b1;
                else
                    cnt <= cnt + CW'(1);
            end else if (pop && !ras_empty) begin
                ptr <= top_idx;
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a queue-based reference model for pc_sequencer
module tb_pc_sequencer;
    localparam int ADDR_W = 64;
    localparam logic [63:0] RPC = 64'h100;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              instr_valid = 1'b0;
    logic [3:0]        icode = 4'h1;
    logic              cnd = 1'b0;
    logic              imem_error = 1'b0;
    logic [ADDR_W-1:0] valC = '0, valM = '0, valP = '0;
    logic [ADDR_W-1:0] pc, ras_top;
    logic [2:0]        stat;
    logic              ras_empty, ras_overflow, ras_mispredict;
    logic [CNT_W-1:0]  retired;

    pc_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RPC), .RAS_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .instr_valid(instr_valid), .icode(icode),
        .cnd(cnd), .imem_error(imem_error), .valC(valC), .valM(valM), .valP(valP),
        .pc(pc), .stat(stat), .ras_top(ras_top), .ras_empty(ras_empty),
        .ras_overflow(ras_overflow), .ras_mispredict(ras_mispredict), .retired(retired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic checking = 1'b0;

    logic [63:0]      m_pc;
    logic [2:0]       m_stat;
    logic [63:0]      m_ras[$];
    logic             m_ovf, m_mis;
    logic [CNT_W-1:0] m_ret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: status is a sticky value, the RAS is an unbounded
    // LIFO queue trimmed from the oldest end whenever it exceeds DEPTH.
    task automatic model_edge();
        if (!rst_n) begin
            m_pc = RPC; m_stat = 3'd1; m_ras.delete(); m_ovf = 0; m_mis = 0; m_ret = '0;
            return;
        end
        m_mis = 0;
        if (en && instr_valid && m_stat == 3'd1) begin
            if (imem_error) m_stat = 3'd3;
            else if (icode > 4'hB) m_stat = 3'd4;
            else begin
                m_ret = m_ret + 1;
                case (icode)
                    4'h0: m_stat = 3'd2;
                    4'h7: m_pc = cnd ? valC : valP;
                    4'h8: begin
                        m_pc = valC;
                        m_ras.push_back(valP);
                        if (m_ras.size() > DEPTH) begin
                            void'(m_ras.pop_front());
                            m_ovf = 1;
                        end
                    end
                    4'h9: begin
                        m_pc = valM;
                        if (m_ras.size() > 0) begin
                            m_mis = m_ras[$] != valM;
                            void'(m_ras.pop_back());
                        end
                    end
                    default: m_pc = valP;
                endcase
            end
        end
    endtask

    always @(negedge clk) if (checking) begin
        chk("pc", pc, m_pc);
        chk("stat", 64'(stat), 64'(m_stat));
        chk("ras_top", ras_top, m_ras.size() > 0 ? m_ras[$] : 64'h0);
        chk("ras_empty", 64'(ras_empty), 64'(m_ras.size() == 0));
        chk("ras_overflow", 64'(ras_overflow), 64'(m_ovf));
        chk("ras_mispredict", 64'(ras_mispredict), 64'(m_mis));
        chk("retired", 64'(retired), 64'(m_ret));
    end

    task automatic cyc(input logic r, input logic e, input logic [3:0] ic, input logic c,
                       input logic ie, input logic [63:0] vc, input logic [63:0] vm,
                       input logic [63:0] vp);
        rst_n = r; en = e; instr_valid = 1'b1; icode = ic; cnd = c; imem_error = ie;
        valC = vc; valM = vm; valP = vp;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic rst();
        cyc(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    endtask

    task automatic op(input logic [3:0] ic, input logic c, input logic [63:0] vc,
                      input logic [63:0] vm, input logic [63:0] vp);
        cyc(1'b1, 1'b1, ic, c, 1'b0, vc, vm, vp);
    endtask

    initial begin
        @(negedge clk);
        rst();
        checking = 1'b1;
        chk("reset_pc", pc, 64'h100);
        chk("reset_empty", 64'(ras_empty), 64'h1);

        op(4'h1, 0, 0, 0, 64'h102);
        op(4'h1, 0, 0, 0, 64'h104);
        op(4'h1, 0, 0, 0, 64'h106);
        chk("seq_pc", pc, 64'h106);
        chk("seq_retired", 64'(retired), 64'd3);
        chk("seq_stat", 64'(stat), 64'd1);

        op(4'h7, 1, 64'h400, 0, 64'h20A);
        chk("jxx_taken", pc, 64'h400);
        op(4'h7, 0, 64'h400, 0, 64'h20A);
        chk("jxx_not_taken", pc, 64'h20A);

        op(4'h8, 0, 64'h500, 0, 64'h109);
        chk("call_pc", pc, 64'h500);
        chk("call_top", ras_top, 64'h109);
        op(4'h9, 0, 0, 64'h109, 0);
        chk("ret_pc", pc, 64'h109);
        chk("ret_empty", 64'(ras_empty), 64'h1);
        chk("ret_no_misp", 64'(ras_mispredict), 64'h0);

        op(4'h8, 0, 64'h500, 0, 64'h109);
        op(4'h9, 0, 0, 64'h999, 0);
        chk("misp_pulse", 64'(ras_mispredict), 64'h1);
        chk("misp_pc", pc, 64'h999);
        op(4'h1, 0, 0, 0, 64'h9A0);
        chk("misp_clear", 64'(ras_mispredict), 64'h0);

        for (int i = 0; i < 9; i++) op(4'h8, 0, 64'h600 + 64'(i), 0, 64'h1000 + 64'(i) * 64'h10);
        chk("overflow", 64'(ras_overflow), 64'h1);
        chk("full_top", ras_top, 64'h1080);
        for (int i = 8; i >= 1; i--) begin
            op(4'h9, 0, 0, 64'h1000 + 64'(i) * 64'h10, 0);
            chk("lifo_pc", pc, 64'h1000 + 64'(i) * 64'h10);
        end
        chk("drained", 64'(ras_empty), 64'h1);
        op(4'h9, 0, 0, 64'h777, 0);
        chk("empty_ret_pc", pc, 64'h777);
        chk("empty_ret_misp", 64'(ras_mispredict), 64'h0);

        op(4'h8, 0, 64'h800, 0, 64'h77A);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 4'h9, 1, 0, 64'h1, 64'h2, 64'h3);
        chk("hold_pc", pc, 64'h800);
        chk("hold_top", ras_top, 64'h77A);
        instr_valid = 1'b0;
        rst_n = 1'b1; en = 1'b1; icode = 4'h1; valP = 64'h55;
        @(posedge clk); model_edge(); @(negedge clk); #1;
        chk("invalid_hold", pc, 64'h800);

        for (int i = 0; i < 4; i++) op(4'h8, 0, 64'h300, 0, 64'h40 + 64'(i));
        rst();
        chk("rst_empty", 64'(ras_empty), 64'h1);
        chk("rst_pc", pc, 64'h100);
        chk("rst_overflow", 64'(ras_overflow), 64'h0);

        op(4'h0, 0, 0, 0, 64'h101);
        chk("halt_stat", 64'(stat), 64'd2);
        op(4'h1, 0, 0, 0, 64'h200);
        op(4'h8, 0, 64'h300, 0, 64'h201);
        chk("halt_frozen_pc", pc, 64'h100);
        chk("halt_frozen_ret", 64'(retired), 64'd1);

        rst();
        cyc(1'b1, 1'b1, 4'h1, 0, 1'b1, 0, 0, 64'h123);
        chk("adr_stat", 64'(stat), 64'd3);
        chk("adr_retired", 64'(retired), 64'd0);
        op(4'h1, 0, 0, 0, 64'h456);
        chk("adr_frozen", pc, 64'h100);

        rst();
        op(4'hC, 0, 0, 0, 64'h111);
        chk("ins_stat", 64'(stat), 64'd4);
        chk("ins_pc", pc, 64'h100);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
